rcb_bank: RTL and testbench
===========================

RCB_BANK -- requirements
Module: rcb_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of RAM channels (symbol/price/volume/order), 1..8.
REQ-002 SHALL have parameter RAM_WIDTH, default 128: data width per channel.
REQ-003 SHALL have parameter ADDR_WIDTH, default 14: address width; depth 2^ADDR_WIDTH per channel.
REQ-004 SHALL have parameter HOST_ARB, default 0: 0 = immediate host writes, 1 = staged writes applied on commit.
REQ-005 SHALL have parameter PEND_DEPTH, default 4: staged-write FIFO depth (power of 2, 2..16).
REQ-006 SHALL have port clk input 1: core clock; one clock only.
REQ-007 SHALL have port reset_n input 1: asynchronous, active-low reset.
REQ-008 SHALL have port t2t_rd_addr input ADDR_WIDTH: feed read address.
REQ-009 SHALL have port sef_read input 1: feed read strobe.
REQ-010 SHALL have port rcb_data output NUM_CH*RAM_WIDTH: channel c at bits [c*RAM_WIDTH +: RAM_WIDTH].
REQ-011 SHALL have port rcb_valid output 1: rcb_data qualifier.
REQ-012 SHALL have port host_req input 1: host request valid.
REQ-013 SHALL have port host_wr input 1: 1 = write, 0 = read.
REQ-014 SHALL have port host_ch input CW: target channel; CW = max(1,clog2(NUM_CH)).
REQ-015 SHALL have port host_addr input ADDR_WIDTH: host address.
REQ-016 SHALL have port host_wdata input RAM_WIDTH: host write data.
REQ-017 SHALL have port host_gnt output 1: request accepted this cycle.
REQ-018 SHALL have port host_rdata output RAM_WIDTH: host read data.
REQ-019 SHALL have port host_rvalid output 1: host_rdata qualifier.
REQ-020 SHALL have port commit input 1: apply staged writes (HOST_ARB=1 only).
REQ-021 SHALL have port commit_done output 1: one-cycle pulse when drain completes.
REQ-022 SHALL have port pend_full output 1: staged-write FIFO full.

Function
REQ-023 SHALL implement one dual-port RAM per channel: port A feed read (all channels, same address), port B host.
REQ-024 SHALL assert rcb_valid exactly 2 cycles after sef_read, with rcb_data read at the sampled t2t_rd_addr; back-to-back reads are sustained 1 per cycle with no stall.
REQ-025 SHALL be write-first: a feed read in the same cycle as a port-B write to the same channel/address SHALL return the new data for that channel.
REQ-026 SHALL, in HOST_ARB=0, grant every host_req in its cycle; writes hit RAM that cycle; reads return host_rvalid 2 cycles after grant.
REQ-027 SHALL, in HOST_ARB=1, use FSM states IDLE and DRAIN, with reset to IDLE.
REQ-028 SHALL, in IDLE, grant a write only if FIFO not full and enqueue {ch,addr,data}; a write in DRAIN or with FIFO full SHALL see host_gnt=0.
REQ-029 SHALL, in HOST_ARB=1, grant reads only in IDLE with FIFO empty; reads never observe staged data.
REQ-030 SHALL transition IDLE->DRAIN on commit when FIFO non-empty (including a write enqueued that same cycle); commit with empty FIFO and no same-cycle write SHALL be ignored with no commit_done.
REQ-031 SHALL, in DRAIN, write one FIFO entry per cycle in order to port B; after the last entry return to IDLE and pulse commit_done that cycle; drain of N entries takes exactly N cycles.
REQ-032 SHALL ignore commit while in DRAIN.
REQ-033 SHALL drive pend_full = FIFO count == PEND_DEPTH; always 0 in HOST_ARB=0.
REQ-034 SHALL tie commit_done and pend_full to 0 in HOST_ARB=0, with commit ignored.

Reset
REQ-035 SHALL, while reset_n=0, clear rcb_valid, host_gnt, host_rvalid, commit_done, pend_full, rcb_data and host_rdata to 0, and reset the FSM to IDLE with an empty FIFO.
REQ-036 SHALL, on reset mid-DRAIN, discard undrained entries while leaving already written RAM words intact; RAM contents are not reset.
REQ-037 SHALL drop in-flight read pipeline stages on reset, producing no valid after deassertion.

Verification
REQ-038 SHALL verify: HOST_ARB=0, write ch2 addr 0x10 = 0xAB; next cycle sef_read addr 0x10 -> 2 cycles later rcb_data ch2 = 0xAB, rcb_valid=1.
REQ-039 SHALL verify: same-cycle host write ch1 addr 5 = 0x77 and sef_read addr 5 -> ch1 slice = 0x77 (write-first).
REQ-040 SHALL verify: HOST_ARB=1, PEND_DEPTH=4, four writes -> pend_full=1, fifth gnt=0; feed reads still return old data.
REQ-041 SHALL verify: commit after 3 staged writes -> DRAIN for 3 cycles, commit_done on 3rd, feed reads then return new data.
REQ-042 SHALL verify: commit with empty FIFO -> no state change and no commit_done; commit together with first write -> 1-cycle drain.
REQ-043 SHALL verify: reset_n low on 2nd drain cycle -> first entry in RAM, remaining absent, FIFO empty, all outputs 0.

Source files
------------

// File: rtl/rcb_bank_if.sv
// Feed-read and host-access signal bundle for rcb_bank.
// slave = the bank itself, master = whoever drives the feed and host sides.
interface rcb_bank_if #(
  parameter int NUM_CH     = 4,
  parameter int RAM_WIDTH  = 128,
  parameter int ADDR_WIDTH = 14,
  parameter int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [ADDR_WIDTH-1:0]       t2t_rd_addr;
  logic                        sef_read;
  logic [NUM_CH*RAM_WIDTH-1:0] rcb_data;
  logic                        rcb_valid;
  logic                        host_req;
  logic                        host_wr;
  logic [CW-1:0]               host_ch;
  logic [ADDR_WIDTH-1:0]       host_addr;
  logic [RAM_WIDTH-1:0]        host_wdata;
  logic                        host_gnt;
  logic [RAM_WIDTH-1:0]        host_rdata;
  logic                        host_rvalid;
  logic                        commit;
  logic                        commit_done;
  logic                        pend_full;

  modport slave (
    input  t2t_rd_addr, sef_read, host_req, host_wr, host_ch, host_addr, host_wdata, commit,
    output rcb_data, rcb_valid, host_gnt, host_rdata, host_rvalid, commit_done, pend_full
  );
  modport master (
    output t2t_rd_addr, sef_read, host_req, host_wr, host_ch, host_addr, host_wdata, commit,
    input  rcb_data, rcb_valid, host_gnt, host_rdata, host_rvalid, commit_done, pend_full
  );
endinterface

// File: rtl/rcb_bank.sv
// Multi-channel dual-port RAM bank: port A is a shared feed read across all channels,
// port B is host access, either immediate or staged in a FIFO and drained on commit.

module rcb_ch_ram #(
  parameter int W  = 128,
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          a_en,
  input  logic [AW-1:0] a_addr,
  output logic [W-1:0]  a_q,
  input  logic          b_en,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [W-1:0]  b_wdata,
  output logic [W-1:0]  b_q
);
  logic [W-1:0] mem [2**AW];

  // Feed port forwards a same-cycle port-B write to the same word (write-first).
  always_ff @(posedge clk) begin
    if (b_en && b_we) mem[b_addr] <= b_wdata;
    if (a_en) a_q <= (b_en && b_we && (b_addr == a_addr)) ? b_wdata : mem[a_addr];
    if (b_en && !b_we) b_q <= mem[b_addr];
  end
endmodule

module rcb_bank #(
  parameter int NUM_CH     = 4,
  parameter int RAM_WIDTH  = 128,
  parameter int ADDR_WIDTH = 14,
  parameter int HOST_ARB   = 0,
  parameter int PEND_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  rcb_bank_if.slave bus
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                        b_act, b_we;
  logic [CW-1:0]               b_ch;
  logic [ADDR_WIDTH-1:0]       b_addr;
  logic [RAM_WIDTH-1:0]        b_wdata;
  logic [NUM_CH-1:0][RAM_WIDTH-1:0] a_q, b_q;
  logic [2:1]                  feed_vld, hrd_vld;
  logic [CW-1:0]               hrd_ch;
  logic [RAM_WIDTH-1:0]        hrd_sel;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rcb_ch_ram #(.W(RAM_WIDTH), .AW(ADDR_WIDTH)) u_ram (
      .clk     (clk),
      .a_en    (bus.sef_read),
      .a_addr  (bus.t2t_rd_addr),
      .a_q     (a_q[c]),
      .b_en    (b_act && (b_ch == CW'(c))),
      .b_we    (b_we),
      .b_addr  (b_addr),
      .b_wdata (b_wdata),
      .b_q     (b_q[c])
    );
  end

  always_comb begin
    hrd_sel = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (hrd_ch == CW'(c)) hrd_sel = b_q[c];
  end

  // Two-stage read pipelines: RAM register, then output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      feed_vld         <= '0;
      hrd_vld          <= '0;
      hrd_ch           <= '0;
      bus.rcb_data     <= '0;
      bus.host_rdata   <= '0;
    end else begin
      feed_vld <= {feed_vld[1], bus.sef_read};
      hrd_vld  <= {hrd_vld[1], b_act & ~b_we};
      hrd_ch   <= b_ch;
      if (feed_vld[1]) bus.rcb_data   <= a_q;
      if (hrd_vld[1])  bus.host_rdata <= hrd_sel;
    end
  end

  assign bus.rcb_valid   = feed_vld[2];
  assign bus.host_rvalid = hrd_vld[2];

  if (HOST_ARB == 0) begin : g_direct
    logic unused_commit;
    assign unused_commit = bus.commit;

    always_comb begin
      b_act   = reset_n & bus.host_req;
      b_we    = bus.host_wr;
      b_ch    = bus.host_ch;
      b_addr  = bus.host_addr;
      b_wdata = bus.host_wdata;
    end

    assign bus.host_gnt    = reset_n & bus.host_req;
    assign bus.commit_done = 1'b0;
    assign bus.pend_full   = 1'b0;
  end else begin : g_staged
    localparam int PW = $clog2(PEND_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(PEND_DEPTH);
    localparam logic [PW:0] ONE  = (PW+1)'(1);

    typedef struct packed {
      logic [CW-1:0]         ch;
      logic [ADDR_WIDTH-1:0] addr;
      logic [RAM_WIDTH-1:0]  data;
    } pend_t;
    typedef enum logic {IDLE, DRAIN} state_t;

    state_t        state, state_nx;
    pend_t         fifo [PEND_DEPTH];
    pend_t         head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count, count_nx;
    logic          wr_gnt, rd_gnt;

    assign head = fifo[rd_ptr];

    // Push only happens in IDLE and pop only in DRAIN, so they never coincide.
    always_comb begin
      wr_gnt   = reset_n && (state == IDLE) && bus.host_req && bus.host_wr && (count != FULL);
      rd_gnt   = reset_n && (state == IDLE) && bus.host_req && !bus.host_wr && (count == '0);
      state_nx = state;
      count_nx = count;
      if (state == DRAIN) begin
        count_nx = count - ONE;
        if (count == ONE) state_nx = IDLE;
      end else begin
        if (wr_gnt) count_nx = count + ONE;
        if (bus.commit && (count_nx != '0)) state_nx = DRAIN;
      end
    end

    always_comb begin
      b_act   = (reset_n && (state == DRAIN)) || rd_gnt;
      b_we    = (state == DRAIN);
      b_ch    = (state == DRAIN) ? head.ch   : bus.host_ch;
      b_addr  = (state == DRAIN) ? head.addr : bus.host_addr;
      b_wdata = head.data;
    end

    assign bus.host_gnt = wr_gnt | rd_gnt;

    always_ff @(posedge clk) begin
      if (wr_gnt) fifo[wr_ptr] <= {bus.host_ch, bus.host_addr, bus.host_wdata};
    end

    // commit_done is registered so it lands on the cycle the last entry is written.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state           <= IDLE;
        count           <= '0;
        wr_ptr          <= '0;
        rd_ptr          <= '0;
        bus.commit_done <= 1'b0;
        bus.pend_full   <= 1'b0;
      end else begin
        state           <= state_nx;
        count           <= count_nx;
        if (wr_gnt)          wr_ptr <= wr_ptr + PW'(1);
        if (state == DRAIN)  rd_ptr <= rd_ptr + PW'(1);
        bus.commit_done <= (state_nx == DRAIN) && (count_nx == ONE);
        bus.pend_full   <= (count_nx == FULL);
      end
    end
  end
endmodule

// File: tb/tb_rcb_bank.sv
// Directed bench for rcb_bank: one immediate-write instance and one staged-write instance.
module tb_rcb_bank;
  localparam int NCH = 4, W = 128, AW = 8, CW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0, n_pass = 0;

  rcb_bank_if #(.NUM_CH(NCH), .RAM_WIDTH(W), .ADDR_WIDTH(AW)) i0 (), i1 ();

  rcb_bank #(.NUM_CH(NCH), .RAM_WIDTH(W), .ADDR_WIDTH(AW), .HOST_ARB(0), .PEND_DEPTH(4)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(i0));
  rcb_bank #(.NUM_CH(NCH), .RAM_WIDTH(W), .ADDR_WIDTH(AW), .HOST_ARB(1), .PEND_DEPTH(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(i1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_all;
    i0.sef_read = 0; i0.t2t_rd_addr = '0; i0.host_req = 0; i0.host_wr = 0;
    i0.host_ch = '0; i0.host_addr = '0; i0.host_wdata = '0; i0.commit = 0;
    i1.sef_read = 0; i1.t2t_rd_addr = '0; i1.host_req = 0; i1.host_wr = 0;
    i1.host_ch = '0; i1.host_addr = '0; i1.host_wdata = '0; i1.commit = 0;
  endtask

  task automatic hw0(input int ch, input int a, input logic [W-1:0] d);
    i0.host_req = 1; i0.host_wr = 1; i0.host_ch = CW'(ch); i0.host_addr = AW'(a); i0.host_wdata = d;
    #1 chk("gnt0_wr", i0.host_gnt, 1);
    tick;
    i0.host_req = 0; i0.host_wr = 0;
  endtask

  task automatic stage1(input int ch, input int a, input logic [W-1:0] d, input logic g, input string tag);
    i1.host_req = 1; i1.host_wr = 1; i1.host_ch = CW'(ch); i1.host_addr = AW'(a); i1.host_wdata = d;
    #1 chk(tag, i1.host_gnt, g);
    tick;
    i1.host_req = 0; i1.host_wr = 0;
  endtask

  task automatic feed(input bit u, input int a, input int ch, input logic [W-1:0] exp, input string tag);
    logic [NCH*W-1:0] d;
    if (u) begin i1.sef_read = 1; i1.t2t_rd_addr = AW'(a); end
    else   begin i0.sef_read = 1; i0.t2t_rd_addr = AW'(a); end
    tick;
    i0.sef_read = 0; i1.sef_read = 0;
    chk({tag, "_early"}, u ? i1.rcb_valid : i0.rcb_valid, 0);
    tick;
    d = u ? i1.rcb_data : i0.rcb_data;
    chk({tag, "_vld"}, u ? i1.rcb_valid : i0.rcb_valid, 1);
    chk(tag, d[ch*W +: W], exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    idle_all;
    i0.host_req = 1; i1.host_req = 1; i0.commit = 1; i1.commit = 1;
    repeat (3) tick;
    chk("rst_gnt0", i0.host_gnt, 0);
    chk("rst_gnt1", i1.host_gnt, 0);
    chk("rst_vld1", i1.rcb_valid, 0);
    chk("rst_rv1", i1.host_rvalid, 0);
    chk("rst_done1", i1.commit_done, 0);
    chk("rst_full1", i1.pend_full, 0);
    chk("rst_data0", i0.rcb_data == '0, 1);
    chk("rst_rdata0", i0.host_rdata, 0);
    idle_all;
    reset_n = 1;
    tick; tick;

    // Immediate-write instance
    hw0(2, 'h10, 'hAB);
    feed(0, 'h10, 2, 'hAB, "wr_then_feed");

    i0.host_req = 1; i0.host_wr = 1; i0.host_ch = 2'd1; i0.host_addr = 8'h05; i0.host_wdata = 'h77;
    i0.sef_read = 1; i0.t2t_rd_addr = 8'h05;
    tick;
    i0.host_req = 0; i0.host_wr = 0; i0.sef_read = 0;
    tick;
    chk("wf_vld", i0.rcb_valid, 1);
    chk("wf_data", i0.rcb_data[W +: W], 'h77);

    i0.host_req = 1; i0.host_wr = 0; i0.host_ch = 2'd2; i0.host_addr = 8'h10;
    #1 chk("hrd_gnt", i0.host_gnt, 1);
    tick;
    i0.host_req = 0;
    chk("hrd_rv_early", i0.host_rvalid, 0);
    tick;
    chk("hrd_rv", i0.host_rvalid, 1);
    chk("hrd_data", i0.host_rdata, 'hAB);
    tick;
    chk("hrd_rv_off", i0.host_rvalid, 0);

    hw0(0, 'h20, 'h11);
    hw0(0, 'h21, 'h22);
    i0.sef_read = 1; i0.t2t_rd_addr = 8'h20; tick;
    i0.t2t_rd_addr = 8'h21; tick;
    i0.sef_read = 0;
    chk("b2b_v0", i0.rcb_valid, 1);
    chk("b2b_d0", i0.rcb_data[0 +: W], 'h11);
    tick;
    chk("b2b_v1", i0.rcb_valid, 1);
    chk("b2b_d1", i0.rcb_data[0 +: W], 'h22);
    tick;
    chk("b2b_off", i0.rcb_valid, 0);

    i0.commit = 1; tick; i0.commit = 0;
    chk("arb0_done", i0.commit_done, 0);
    chk("arb0_full", i0.pend_full, 0);

    // Staged-write instance: empty commit is ignored
    i1.commit = 1; tick; i1.commit = 0;
    chk("ecommit_done", i1.commit_done, 0);
    tick;
    chk("ecommit_done2", i1.commit_done, 0);
    i1.host_req = 1; i1.host_wr = 0; i1.host_ch = '0; i1.host_addr = 8'h03;
    #1 chk("idle_rd_gnt", i1.host_gnt, 1);
    tick; i1.host_req = 0; tick;
    chk("idle_rd_rv", i1.host_rvalid, 1);

    // Commit together with the first write: one-cycle drain
    i1.host_req = 1; i1.host_wr = 1; i1.host_ch = '0; i1.host_addr = 8'h03; i1.host_wdata = 'h33;
    i1.commit = 1;
    #1 chk("cw_gnt", i1.host_gnt, 1);
    tick;
    i1.host_req = 0; i1.host_wr = 0; i1.commit = 0;
    chk("cw_done", i1.commit_done, 1);
    i1.host_req = 1; i1.host_wr = 1; i1.host_addr = 8'h07; i1.host_wdata = 'hFF;
    #1 chk("drain_wr_gnt", i1.host_gnt, 0);
    i1.host_req = 0; i1.host_wr = 0;
    tick;
    chk("cw_done_off", i1.commit_done, 0);
    feed(1, 'h03, 0, 'h33, "cw_feed");

    // Fill the FIFO
    stage1(0, 'h03, 'h99, 1, "s4_g0");
    stage1(1, 'h41, 'hD1, 1, "s4_g1");
    stage1(2, 'h42, 'hD2, 1, "s4_g2");
    chk("pre_full", i1.pend_full, 0);
    stage1(3, 'h43, 'hD3, 1, "s4_g3");
    chk("pend_full", i1.pend_full, 1);
    stage1(3, 'h44, 'hEE, 0, "s5_gnt");
    i1.host_req = 1; i1.host_wr = 0;
    #1 chk("rd_blocked", i1.host_gnt, 0);
    i1.host_req = 0;
    feed(1, 'h03, 0, 'h33, "staged_hidden");
    i1.commit = 1; tick; i1.commit = 0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("d4_done%0d", k), i1.commit_done, (k == 4));
      tick;
    end
    chk("d4_after", i1.commit_done, 0);
    chk("d4_full", i1.pend_full, 0);
    feed(1, 'h03, 0, 'h99, "d4_feed0");
    feed(1, 'h43, 3, 'hD3, "d4_feed3");

    // Three-entry drain, commit held through it
    stage1(1, 'h61, 'h5A, 1, "p0");
    stage1(1, 'h62, 'h5B, 1, "p1");
    stage1(1, 'h60, 'h50, 1, "p2");
    i1.commit = 1; tick;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("d3_done%0d", k), i1.commit_done, (k == 3));
      tick;
    end
    i1.commit = 0;
    chk("d3_after", i1.commit_done, 0);
    tick;
    chk("d3_after2", i1.commit_done, 0);
    feed(1, 'h61, 1, 'h5A, "d3_feed61");
    feed(1, 'h62, 1, 'h5B, "d3_feed62");
    feed(1, 'h60, 1, 'h50, "d3_feed60");

    // Reset on the second drain cycle
    stage1(1, 'h60, 'hE0, 1, "r0");
    stage1(1, 'h61, 'hE1, 1, "r1");
    stage1(1, 'h62, 'hE2, 1, "r2");
    i1.commit = 1; tick; i1.commit = 0;
    tick;
    reset_n = 0;
    i1.host_req = 1; i1.host_wr = 1;
    #1;
    chk("mrst_gnt", i1.host_gnt, 0);
    chk("mrst_done", i1.commit_done, 0);
    chk("mrst_full", i1.pend_full, 0);
    chk("mrst_vld", i1.rcb_valid, 0);
    chk("mrst_rv", i1.host_rvalid, 0);
    chk("mrst_data", i1.rcb_data == '0, 1);
    chk("mrst_rdata", i1.host_rdata, 0);
    chk("mrst_data0", i0.rcb_data == '0, 1);
    tick;
    i1.host_req = 0; i1.host_wr = 0;
    reset_n = 1;
    tick;
    i1.host_req = 1; i1.host_wr = 0;
    #1 chk("post_rst_rd_gnt", i1.host_gnt, 1);
    tick; i1.host_req = 0; tick;
    i1.commit = 1; tick; i1.commit = 0;
    chk("post_rst_commit", i1.commit_done, 0);
    tick;
    chk("post_rst_commit2", i1.commit_done, 0);
    feed(1, 'h60, 1, 'hE0, "mrst_feed60");
    feed(1, 'h61, 1, 'h5A, "mrst_feed61");
    feed(1, 'h62, 1, 'h5B, "mrst_feed62");

    // In-flight feed read dropped by reset
    i0.sef_read = 1; i0.t2t_rd_addr = 8'h10; tick;
    i0.sef_read = 0;
    reset_n = 0;
    #1 chk("inflight_rst_v", i0.rcb_valid, 0);
    tick;
    reset_n = 1;
    tick;
    chk("inflight_v_a", i0.rcb_valid, 0);
    tick;
    chk("inflight_v_b", i0.rcb_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
